// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: op codes, fault codes and sizing helper shared by the PC sequencer.
package pc_seq_pkg;
  typedef enum logic [2:0] {
    OP_HOLD, OP_INC, OP_DEC, OP_JMP, OP_BR, OP_CALL, OP_RET, OP_FLUSH
  } pc_op_e;
  typedef enum logic [1:0] {FC_NONE, FC_OVF, FC_UNF} fault_code_e;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses; only the level is reset, entries persist across pop/flush.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 din,
  output logic [WIDTH-1:0]                 top,
  output logic [lvl_w(STACK_DEPTH)-1:0]    level,
  output logic                             full,
  output logic                             empty
);
  localparam int LW = lvl_w(STACK_DEPTH);
  localparam int AW = $clog2(STACK_DEPTH);
  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [AW-1:0] wi, ti;
  assign full  = level == LW'(STACK_DEPTH);
  assign empty = level == '0;
  assign wi    = AW'(level);
  assign ti    = AW'(level - LW'(1));
  assign top   = mem[ti];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) level <= '0;
    else if (flush) level <= '0;
    else if (push && !full) level <= level + LW'(1);
    else if (pop && !empty) level <= level - LW'(1);
  always_ff @(posedge clk)
    if (push && !full) mem[wi] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with inc/dec/jump/branch, call/return stack and sticky stack fault.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [2:0]                    op,
  input  logic [WIDTH-1:0]              operand,
  input  logic                          cond,
  input  logic                          fault_clr,
  output logic [WIDTH-1:0]              pc_out,
  output logic [lvl_w(STACK_DEPTH)-1:0] stack_level,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          fault,
  output logic [1:0]                    fault_code
);
  pc_op_e           cur;
  fault_code_e      code_q;
  logic             go, is_call, is_ret, ovf, unf;
  logic [WIDTH-1:0] inc, pc_next, top;
  assign cur        = pc_op_e'(op);
  assign go         = enable && !fault_clr && !fault;
  assign is_call    = go && cur == OP_CALL;
  assign is_ret     = go && cur == OP_RET;
  assign ovf        = is_call && stack_full;
  assign unf        = is_ret && stack_empty;
  assign inc        = pc_out + WIDTH'(1);
  assign fault_code = code_q;
  ret_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .reset_n(reset_n),
    .push(is_call && !stack_full),
    .pop(is_ret && !stack_empty),
    .flush(go && cur == OP_FLUSH),
    .din(inc),
    .top(top),
    .level(stack_level),
    .full(stack_full),
    .empty(stack_empty)
  );
  // Rejected CALL/RET keep the current PC; the fault register records why.
  always_comb begin
    pc_next = pc_out;
    case (cur)
      OP_INC:   pc_next = inc;
      OP_DEC:   pc_next = pc_out - WIDTH'(1);
      OP_JMP:   pc_next = operand;
      OP_BR:    pc_next = cond ? pc_out + operand : inc;
      OP_CALL:  pc_next = stack_full ? pc_out : operand;
      OP_RET:   pc_next = stack_empty ? pc_out : top;
      OP_FLUSH: pc_next = inc;
      default:  pc_next = pc_out;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_out <= RESET_VECTOR;
      fault  <= 1'b0;
      code_q <= FC_NONE;
    end else if (fault_clr) begin
      fault  <= 1'b0;
      code_q <= FC_NONE;
    end else if (go) begin
      pc_out <= pc_next;
      if (ovf || unf) begin
        fault  <= 1'b1;
        code_q <= ovf ? FC_OVF : FC_UNF;
      end
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Parametrised program-counter sequencer; the next generation of the CPU's 16-bit load/enable counter.
- Supports increment, decrement, absolute jump, conditional relative branch, and call/return through an internal return-address stack.
- Detects stack overflow and underflow with a sticky fault.
- Sits between the instruction decoder (drives `op`, `operand` and `cond`) and instruction fetch (consumes `pc_out`).

## Interface
- `WIDTH`, 16: PC and operand width in bits; minimum 4.
- `STACK_DEPTH`, 8: return-stack entries; minimum 2.
- `RESET_VECTOR`, 0: PC value after reset.
- `clk`  in  1  — single clock; all logic on its rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — execute `op` this cycle; when low, all state holds.
- `op`  in  3  — operation code (see Operation).
- `operand`  in  WIDTH  — absolute target (JMP/CALL/LOAD) or signed two's-complement offset (BR).
- `cond`  in  1  — branch condition; sampled only for BR.
- `fault_clr`  in  1  — clears the sticky fault.
- `pc_out`  out  WIDTH  — current PC; registered.
- `stack_level`  out  clog2(STACK_DEPTH+1)  — number of valid stack entries.
- `stack_full`  out  1  — `stack_level == STACK_DEPTH`.
- `stack_empty`  out  1  — `stack_level == 0`.
- `fault`  out  1  — sticky error flag.
- `fault_code`  out  2  — 0 none, 1 overflow, 2 underflow; holds the first error until cleared.

## Operation
- **Op codes**:
  - 0 HOLD: no change.
  - 1 INC: pc+1.
  - 2 DEC: pc−1.
  - 3 JMP: pc=operand.
  - 4 BR: if `cond`, pc=pc+operand (signed); else pc+1.
  - 5 CALL: push pc+1, then pc=operand.
  - 6 RET: pop, and pc=popped value.
  - 7 FLUSH: stack_level=0, pc+1.
- **Arithmetic**: all PC arithmetic is modulo 2^WIDTH.
  - All-ones +1 wraps to 0; 0 −1 wraps to all-ones.
  - BR offset is not sign-extended; it is already WIDTH wide. The sum is truncated to WIDTH.
- **Priority**, highest first: `reset_n` low > `fault_clr` > (`fault` set → freeze) > `enable`/`op`.
- **`fault_clr` high**: clears `fault` and `fault_code`; `op` is ignored that cycle even if `enable` is high.
- **While `fault`=1**: PC and stack are frozen regardless of `enable`/`op`.
- **Overflow**: CALL with `stack_full`:
  - PC and stack unchanged.
  - `fault`=1, `fault_code`=1.
- **Underflow**: RET with `stack_empty`:
  - PC unchanged.
  - `fault`=1, `fault_code`=2.
- **Stack behaviour**:
  - Stack is LIFO; entries are not cleared on pop or FLUSH, only the level changes.
  - Stack contents are undefined after reset; only the level is defined.
- **Reserved behaviour**: none. All 8 codes are defined; any op with `enable` low behaves as HOLD.

## Timing
- **Reset values** (while `reset_n` low, asynchronously):
  - `pc_out`=RESET_VECTOR, `stack_level`=0, `stack_empty`=1, `stack_full`=0, `fault`=0, `fault_code`=0.
- **Reset release**: deassertion is sampled synchronously; first operation executes on the first rising edge with `reset_n` high.
- **Latency**: one cycle. The op sampled at edge N is reflected on `pc_out`/`stack_level` after edge N.
  - Stack flags are derived combinationally from the registered level, so they also update after edge N.
- **Back-to-back**: CALL then RET on consecutive cycles returns to the original pc+1; no bubble required.
- **Fault timing**: `fault` rises on the same edge that rejects the CALL/RET.
- **Reset mid-operation**: a reset assertion in any cycle discards the in-flight op; no partial stack write survives.
- **Inputs**: all inputs are synchronous to `clk`; no combinational path from input to output.

## Structure
- **Package `pc_seq_pkg`**:
  - `pc_op_e` enum for the 8 op codes.
  - `fault_code_e` enum (NONE, OVF, UNF).
  - Helper function for the stack-level width, clog2(STACK_DEPTH+1).
- **Sub-module `ret_stack`**:
  - Parametrised LIFO (WIDTH, STACK_DEPTH) with push/pop/flush inputs.
  - Registered level; async active-low reset of the level only.
  - Exposes top, full and empty.
  - Push and pop are never asserted together; the parent guarantees this.
- **Top level**: next-PC mux and fault register.

## Test plan
- **Reset and increment**: reset, then enable INC ×3 → `pc_out` 0,1,2,3; assert `reset_n` low mid-run → `pc_out`=0 immediately, `stack_level`=0.
- **Wrap-around**:
  - Wrap up: LOAD 0xFFFF via JMP, then INC → 0x0000.
  - Wrap down: DEC from 0x0000 → 0xFFFF.
  - Branch: at pc=0x0010, BR with operand 0xFFF0 and `cond`=1 → 0x0000; with `cond`=0 → 0x0011.
- **Nested calls**: from pc=0x0100, CALL 0x0200; then at 0x0200, CALL 0x0300 → `stack_level` 2; RET, RET → pc 0x0201 then 0x0101, `stack_empty`=1.
- **Overflow**: (STACK_DEPTH=8) 8 CALLs → `stack_full`=1; 9th CALL → pc unchanged, `fault`=1, `fault_code`=1; INC ignored while faulted; `fault_clr` with INC in same cycle → fault cleared, pc unchanged; next INC advances.
- **Underflow and flush**: RET on empty stack → `fault_code`=2, pc unchanged. After clearing: CALL ×3, then FLUSH → `stack_level`=0 and pc=pc+1; a following RET faults with code 2.
- **Enable low**: `enable` low with op=CALL for 5 cycles → no change to pc, `stack_level` or `fault`.
